// File: rtl/usb_pkt_tx.sv
// USB 2.0 FS device-side packet transmitter: emits PID, optional payload and CRC16
// onto the 8-bit UTMI transmit interface under the tx_valid/tx_ready handshake.
module usb_pkt_tx #(
    parameter int unsigned MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_start,
    input  logic [3:0] pkt_pid,
    input  logic       pkt_zlp,
    input  logic [7:0] pld_data,
    input  logic       pld_valid,
    input  logic       pld_last,
    output logic       pld_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] data_in,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int unsigned CNT_W  = 11;
    localparam int unsigned CRC_W  = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LEN);
    localparam logic [CRC_W-1:0] CRC_POLY = 16'hA001;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_DATA,
        S_CRC_LO,
        S_CRC_HI
    } state_e;

    // Reflected CRC-16/USB, one byte processed LSB first.
    function automatic logic [CRC_W-1:0] crc16_byte(input logic [CRC_W-1:0] crc,
                                                    input logic [BYTE_W-1:0] d);
        logic [CRC_W-1:0] c;
        c = crc ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                txv_q, txv_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_data_q, is_data_d;
    logic                zlp_q, zlp_d;
    logic                cur_last_q, cur_last_d;
    logic                trunc_q, trunc_d;

    logic accept;
    logic at_limit;
    logic fetch;

    assign accept   = txv_q & tx_ready;
    assign at_limit = (cnt_q == MAX_CNT);

    // A fetch pulls the next payload byte in the same cycle the current byte is accepted.
    assign fetch = accept &
                   (((state_q == S_PID) & is_data_q & ~zlp_q) |
                    ((state_q == S_DATA) & ~cur_last_q & ~at_limit));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pkt_start) state_d = S_PID;
            end
            S_PID: begin
                if (accept) begin
                    if (!is_data_q)  state_d = S_IDLE;
                    else if (zlp_q)  state_d = S_CRC_LO;
                end
            end
            S_DATA: begin
                if (accept && (cur_last_q || at_limit)) state_d = S_CRC_LO;
            end
            S_CRC_LO: begin
                if (accept) state_d = S_CRC_HI;
            end
            S_CRC_HI: begin
                if (accept) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (fetch) state_d = pld_valid ? S_DATA : S_IDLE;
    end

    always_comb begin
        data_d     = data_q;
        txv_d      = txv_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        is_data_d  = is_data_q;
        zlp_d      = zlp_q;
        cur_last_d = cur_last_q;
        trunc_d    = trunc_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        busy_d     = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (pkt_start) begin
                    data_d     = {~pkt_pid, pkt_pid};
                    txv_d      = 1'b1;
                    is_data_d  = (pkt_pid[1:0] == 2'b11);
                    zlp_d      = pkt_zlp;
                    crc_d      = CRC_INIT;
                    cnt_d      = '0;
                    cur_last_d = 1'b0;
                    trunc_d    = 1'b0;
                end
            end
            S_PID: begin
                if (accept) begin
                    if (!is_data_q) begin
                        txv_d  = 1'b0;
                        done_d = 1'b1;
                    end else if (zlp_q) begin
                        data_d = ~crc_q[7:0];
                    end
                end
            end
            S_DATA: begin
                if (accept && (cur_last_q || at_limit)) begin
                    data_d  = ~crc_q[7:0];
                    trunc_d = ~cur_last_q;
                end
            end
            S_CRC_LO: begin
                if (accept) data_d = ~crc_q[15:8];
            end
            S_CRC_HI: begin
                if (accept) begin
                    txv_d  = 1'b0;
                    done_d = 1'b1;
                    err_d  = trunc_q;
                end
            end
            default: ;
        endcase
        // Payload load or underrun abort; an underrun sends no CRC.
        if (fetch) begin
            if (pld_valid) begin
                data_d     = pld_data;
                crc_d      = crc16_byte(crc_q, pld_data);
                cnt_d      = cnt_q + CNT_W'(1);
                cur_last_d = pld_last;
            end else begin
                txv_d  = 1'b0;
                done_d = 1'b1;
                err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            txv_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            crc_q      <= CRC_INIT;
            cnt_q      <= '0;
            is_data_q  <= 1'b0;
            zlp_q      <= 1'b0;
            cur_last_q <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            data_q     <= data_d;
            txv_q      <= txv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            is_data_q  <= is_data_d;
            zlp_q      <= zlp_d;
            cur_last_q <= cur_last_d;
            trunc_q    <= trunc_d;
        end
    end

    assign pld_ready = fetch;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign data_in   = data_q;
    assign tx_valid  = txv_q;

endmodule

// File: doc/usb_pkt_tx.md
# usb_pkt_tx

Device-side packet transmitter of the USB 2.0 FS serial interface engine, driving the transmit half of the 8-bit UTMI toward `usb_utm`. It takes a packet request (PID plus optional payload stream) from the protocol layer and emits the PID byte, any payload bytes and the CRC16 on `data_in` under the `tx_valid`/`tx_ready` handshake. Handshake packets carry the PID only; data packets carry PID, payload and CRC16.

## Interface
Parameters:
- MAX_LEN, 64, maximum payload bytes per data packet (1..1023).

Ports:
- clk  in  1  Clock.
- rst  in  1  Reset, asynchronous, active-high.
- pkt_start  in  1  Packet request. Sampled only in IDLE.
- pkt_pid  in  4  PID[3:0], sampled with pkt_start.
- pkt_zlp  in  1  Zero-length data packet, sampled with pkt_start.
- pld_data  in  8  Payload byte.
- pld_valid  in  1  pld_data is valid.
- pld_last  in  1  Current payload byte is the final byte.
- pld_ready  out  1  Payload byte consumed this cycle. Combinational.
- busy  out  1  High in every state except IDLE.
- done  out  1  One-cycle pulse when a packet ends, whether it completes or aborts.
- err  out  1  One-cycle pulse coincident with done on underrun or truncation.
- data_in  out  8  UTMI transmit byte. Registered.
- tx_valid  out  1  UTMI transmit valid. Registered.
- tx_ready  in  1  UTMI: the UTM accepted data_in this cycle.

## Operation
- Reset values: data_in=0x00, tx_valid=0, busy=0, done=0, err=0, pld_ready=0. State is IDLE and the CRC register is 0xFFFF.
- A byte is accepted on a cycle with tx_valid & tx_ready. data_in changes only on accept cycles or when leaving IDLE.
- PID byte = {~pkt_pid, pkt_pid}. A packet is a data packet when pkt_pid[1:0]==2'b11. Every other PID is sent PID-only.
- CRC16 follows CRC-16/USB:
  - polynomial 0x8005, reflected (0xA001), LSB first;
  - initialised to 0xFFFF when leaving IDLE;
  - updated with each payload byte as it is loaded into data_in;
  - transmitted as ~crc[7:0] then ~crc[15:8].
- The payload counter cnt is 11 bits. It is cleared when leaving IDLE and incremented on each payload load.
- States:
  - IDLE: when pkt_start=1, load the PID byte, set tx_valid=1, latch packet kind and zlp, go to PID. pkt_start is ignored in every other state.
  - PID, on accept:
    - handshake packet: tx_valid=0, pulse done, go to IDLE;
    - data packet with zlp: load ~crc[7:0], go to CRC_LO;
    - otherwise: fetch.
  - DATA, on accept:
    - the loaded byte was last (pld_last) or cnt==MAX_LEN: load ~crc[7:0], go to CRC_LO;
    - otherwise: fetch.
  - CRC_LO, on accept: load ~crc[15:8], go to CRC_HI.
  - CRC_HI, on accept: tx_valid=0, pulse done, go to IDLE.
- Fetch happens in the accept cycle:
  - pld_ready=1 (pld_ready = accept & fetch-state);
  - if pld_valid=1: load pld_data into data_in, update CRC, latch pld_last into cur_last, go to or stay in DATA;
  - if pld_valid=0 (underrun): tx_valid=0, pulse done and err, go to IDLE. No CRC is sent.
- Truncation: if cnt reaches MAX_LEN with cur_last=0, the packet finishes normally with the CRC over the MAX_LEN bytes sent. err pulses together with done.
- The MAX_LEN limit has no effect on PID-only or zlp packets.

## Timing
- tx_valid rises on the cycle after pkt_start is sampled in IDLE.
- The next byte is on data_in on the cycle after each accept.
- tx_valid falls on the cycle after the final accept. done and err are registered and pulse that same cycle, and busy falls that same cycle.
- A new pkt_start is accepted in the first IDLE cycle, so the minimum gap is one cycle with tx_valid low.
- tx_ready is legal at any duty cycle, including every cycle.
- pld_valid is examined only in accept cycles of fetch states.
- rst asserted mid-packet returns all outputs to reset values immediately. No done is generated.

## Test plan
- ACK: pkt_pid=4'b0010 -> data_in 0xD2, exactly one accept, then tx_valid=0; done=1 for one cycle; pld_ready never 1.
- DATA0 zero-length: pkt_pid=4'b0011, pkt_zlp=1 -> bytes 0xC3, 0x00, 0x00; err=0.
- DATA1 with payload 0x31..0x39 ("123456789"), pld_last on 0x39, tx_ready asserted 1 cycle in 4 -> bytes 0x4B, 0x31..0x39, 0xC8, 0xB4; pld_ready pulses exactly 9 times.
- Underrun: DATA0, pld_valid=0 at the 3rd payload accept -> 2 payload bytes sent; tx_valid drops the next cycle; done=err=1 for one cycle; no CRC bytes.
- Truncation: MAX_LEN=4 with 6 payload bytes 0x01..0x06 offered -> 4 payload bytes, then CRC-16/USB of 0x01..0x04; err=1 with done; pld_ready pulses 4 times.
- Reset mid-payload, then ACK request -> outputs at reset values during rst; next packet 0xD2 is correct; pkt_start asserted while busy is ignored.
